div_ctrl: RTL and testbench

// Sequencer between the EX stage and the iterative divider (DIV/DIVU/REM/REMU).

---
 rtl/div_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_div_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_ctrl.sv
// div_ctrl: sequencer between the EX stage and the iterative divider.
// Captures a divide request, holds the divider start line for the whole
// operation, stalls the pipeline, and returns a one-cycle writeback.
// It also keeps a last-result cache, aborts on flush, and has a watchdog.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   req_valid_i       EX holds a divide op (held stable while stall_o=1)
//   op_i              funct3: 100 DIV, 101 DIVU, 110 REM, 111 REMU
//   rs1_i, rs2_i      dividend / divisor
//   rd_i              destination register
//   flush_i           pipeline flush, aborts the current op
//   stall_o           hold EX/IF/ID (combinational)
//   wb_valid_o        one-cycle result-valid pulse (registered)
//   wb_rd_o, wb_data_o writeback register / data, valid with wb_valid_o
//   err_o             one-cycle pulse on watchdog timeout
//   div_start_o       divider start, high until the divider reports ready
//   div_dividend_o, div_divisor_o, div_op_o, div_waddr_o
//                     registered copies of the captured request
//   div_res_i, div_ready_i  divider result and done pulse
module div_ctrl #(
  parameter bit          CACHE_EN    = 1'b1,
  parameter int unsigned TIMEOUT_CYC = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] rs1_i,
  input  logic [31:0] rs2_i,
  input  logic [4:0]  rd_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        wb_valid_o,
  output logic [4:0]  wb_rd_o,
  output logic [31:0] wb_data_o,
  output logic        err_o,
  output logic        div_start_o,
  output logic [31:0] div_dividend_o,
  output logic [31:0] div_divisor_o,
  output logic [2:0]  div_op_o,
  output logic [4:0]  div_waddr_o,
  input  logic [31:0] div_res_i,
  input  logic        div_ready_i
);

  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_WB   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] rs1_q, rs1_d;
  logic [31:0] rs2_q, rs2_d;
  logic [4:0]  rd_q, rd_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        cache_vld_q, cache_vld_d;
  logic [2:0]  cache_op_q, cache_op_d;
  logic [31:0] cache_rs1_q, cache_rs1_d;
  logic [31:0] cache_rs2_q, cache_rs2_d;
  logic [31:0] cache_data_q, cache_data_d;
  logic [WD_W-1:0] wdog_q, wdog_d;

  logic req_go;
  logic cache_hit;
  logic timeout;

  assign req_go    = req_valid_i & ~flush_i;
  assign cache_hit = CACHE_EN && cache_vld_q && (cache_op_q == op_i) &&
                     (cache_rs1_q == rs1_i) && (cache_rs2_q == rs2_i);
  // wdog_q holds the number of RUN cycles already spent, so this fires on
  // the TIMEOUT_CYC-th RUN cycle.
  assign timeout   = (wdog_q == WD_W'(TIMEOUT_CYC - 1));

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    rs1_d        = rs1_q;
    rs2_d        = rs2_q;
    rd_d         = rd_q;
    wb_rd_d      = wb_rd_q;
    wb_data_d    = wb_data_q;
    cache_vld_d  = cache_vld_q;
    cache_op_d   = cache_op_q;
    cache_rs1_d  = cache_rs1_q;
    cache_rs2_d  = cache_rs2_q;
    cache_data_d = cache_data_q;
    wdog_d       = '0;
    stall_o      = 1'b0;
    div_start_o  = 1'b0;
    err_o        = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Writes to x0 are dropped without touching the divider.
        if (req_go && (rd_i != 5'd0)) begin
          stall_o = 1'b1;
          if (cache_hit) begin
            wb_rd_d   = rd_i;
            wb_data_d = cache_data_q;
            state_d   = S_WB;
          end else begin
            op_d    = op_i;
            rs1_d   = rs1_i;
            rs2_d   = rs2_i;
            rd_d    = rd_i;
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        stall_o = req_go;
        wdog_d  = wdog_q + WD_W'(1);
        if (flush_i) begin
          state_d = S_IDLE;
        end else if (div_ready_i) begin
          // Start drops in the ready cycle so the divider cannot re-latch.
          wb_rd_d      = rd_q;
          wb_data_d    = div_res_i;
          cache_vld_d  = 1'b1;
          cache_op_d   = op_q;
          cache_rs1_d  = rs1_q;
          cache_rs2_d  = rs2_q;
          cache_data_d = div_res_i;
          state_d      = S_WB;
        end else if (timeout) begin
          err_o   = 1'b1;
          state_d = S_IDLE;
        end else begin
          div_start_o = 1'b1;
        end
      end
      S_WB: begin
        // The instruction is committed; leave regardless of flush/request.
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Reset must kill the combinational outputs in the same cycle.
    if (rst) begin
      stall_o     = 1'b0;
      div_start_o = 1'b0;
      err_o       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      op_q         <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      rd_q         <= '0;
      wb_rd_q      <= '0;
      wb_data_q    <= '0;
      cache_vld_q  <= 1'b0;
      cache_op_q   <= '0;
      cache_rs1_q  <= '0;
      cache_rs2_q  <= '0;
      cache_data_q <= '0;
      wdog_q       <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      rs1_q        <= rs1_d;
      rs2_q        <= rs2_d;
      rd_q         <= rd_d;
      wb_rd_q      <= wb_rd_d;
      wb_data_q    <= wb_data_d;
      cache_vld_q  <= cache_vld_d;
      cache_op_q   <= cache_op_d;
      cache_rs1_q  <= cache_rs1_d;
      cache_rs2_q  <= cache_rs2_d;
      cache_data_q <= cache_data_d;
      wdog_q       <= wdog_d;
    end
  end

  assign wb_valid_o     = (state_q == S_WB);
  assign wb_rd_o        = wb_valid_o ? wb_rd_q : 5'd0;
  assign wb_data_o      = wb_valid_o ? wb_data_q : 32'd0;
  assign div_dividend_o = rs1_q;
  assign div_divisor_o  = rs2_q;
  assign div_op_o       = op_q;
  assign div_waddr_o    = rd_q;

endmodule

// File: tb/tb_div_ctrl.sv
module tb_div_ctrl;

  localparam int TIMEOUT_CYC = 40;
  localparam logic [2:0] OP_DIV = 3'b100, OP_DIVU = 3'b101,
                         OP_REM = 3'b110, OP_REMU = 3'b111;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_i;
  logic [2:0]  op_i;
  logic [31:0] rs1_i, rs2_i;
  logic [4:0]  rd_i;
  logic        flush_i;
  logic        stall_o, wb_valid_o, err_o, div_start_o;
  logic [4:0]  wb_rd_o, div_waddr_o;
  logic [31:0] wb_data_o, div_dividend_o, div_divisor_o;
  logic [2:0]  div_op_o;
  logic [31:0] div_res_i;
  logic        div_ready_i;

  int n_chk  = 0;
  int n_fail = 0;

  // divider stub control
  bit hang = 0;

  // reference cache: last completed divider operation
  bit          rc_vld = 0;
  logic [2:0]  rc_op;
  logic [31:0] rc_a, rc_b;

  div_ctrl #(.CACHE_EN(1'b1), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk(clk), .rst(rst), .req_valid_i(req_valid_i), .op_i(op_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i), .flush_i(flush_i),
    .stall_o(stall_o), .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o),
    .wb_data_o(wb_data_o), .err_o(err_o), .div_start_o(div_start_o),
    .div_dividend_o(div_dividend_o), .div_divisor_o(div_divisor_o),
    .div_op_o(div_op_o), .div_waddr_o(div_waddr_o),
    .div_res_i(div_res_i), .div_ready_i(div_ready_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // RISC-V M-extension semantics
  function automatic logic [31:0] ref_div(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    case (op)
      OP_DIV:  if (b == 0) return 32'hFFFF_FFFF;
               else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
               else return sa / sb;
      OP_DIVU: if (b == 0) return 32'hFFFF_FFFF; else return a / b;
      OP_REM:  if (b == 0) return a;
               else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
               else return sa % sb;
      default: if (b == 0) return a; else return a % b;
    endcase
  endfunction

  // Divider stub: ready after 35 consecutive start cycles (2 for divisor 0).
  initial begin
    int  cnt;
    bit  s;
    cnt = 0;
    div_ready_i = 1'b0;
    div_res_i   = '0;
    forever begin
      @(negedge clk);
      s = div_start_o;
      @(posedge clk);
      #1;
      cnt = s ? cnt + 1 : 0;
      div_ready_i = !hang && (cnt == ((div_divisor_o == 0) ? 2 : 35));
      div_res_i   = div_ready_i ? ref_div(div_op_o, div_dividend_o, div_divisor_o) : 32'd0;
    end
  end

  task automatic drive_req(input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] rd);
    req_valid_i = 1'b1;
    op_i = op; rs1_i = a; rs2_i = b; rd_i = rd;
  endtask

  task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd);
    bit hit;
    int exp_lat, wb_cyc, starts, stall_lo, errs;
    logic [31:0] data;
    logic [4:0]  wrd;
    hit     = rc_vld && rc_op == op && rc_a == a && rc_b == b;
    exp_lat = hit ? 1 : (b == 0 ? 4 : 37);
    wb_cyc = -1; starts = 0; stall_lo = 0; errs = 0; data = '0; wrd = '0;
    @(posedge clk);
    #1;
    drive_req(op, a, b, rd);
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      if (wb_valid_o) begin
        wb_cyc = cyc; data = wb_data_o; wrd = wb_rd_o;
        chk({tag, ".stall_wb"}, 32'(stall_o), 0);
        break;
      end
      if (!stall_o) stall_lo++;
      if (div_start_o) starts++;
      if (err_o) errs++;
    end
    chk({tag, ".lat"}, wb_cyc, exp_lat);
    chk({tag, ".data"}, data, ref_div(op, a, b));
    chk({tag, ".rd"}, 32'(wrd), 32'(rd));
    chk({tag, ".stall"}, stall_lo, 0);
    chk({tag, ".starts"}, starts, hit ? 0 : exp_lat - 2);
    chk({tag, ".err"}, errs, 0);
    if (!hit) begin
      rc_vld = 1; rc_op = op; rc_a = a; rc_b = b;
    end
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".wb_valid"}, 32'(wb_valid_o), 0);
    chk({tag, ".wb_data"}, wb_data_o, 0);
    chk({tag, ".wb_rd"}, 32'(wb_rd_o), 0);
    chk({tag, ".stall"}, 32'(stall_o), 0);
    chk({tag, ".err"}, 32'(err_o), 0);
    chk({tag, ".start"}, 32'(div_start_o), 0);
    chk({tag, ".dividend"}, div_dividend_o, 0);
    chk({tag, ".divisor"}, div_divisor_o, 0);
    chk({tag, ".op"}, 32'(div_op_o), 0);
    chk({tag, ".waddr"}, 32'(div_waddr_o), 0);
  endtask

  initial begin
    int cnt;
    logic [2:0]  op;
    logic [31:0] a, b;
    rst = 1'b1; req_valid_i = 1'b0; op_i = '0; rs1_i = '0; rs2_i = '0;
    rd_i = '0; flush_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk_all_zero("reset");

    do_op("divu_100_7", OP_DIVU, 100, 7, 5);
    do_op("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 2, 6);
    do_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 2, 6);
    do_op("div_by0", OP_DIV, 1234, 0, 8);
    do_op("remu_by0", OP_REMU, 1234, 0, 8);
    do_op("div_50_5", OP_DIV, 50, 5, 10);
    do_op("div_50_5_hit", OP_DIV, 50, 5, 11);
    do_op("rem_50_5", OP_REM, 50, 5, 12);
    do_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 13);

    // flush at cycle 10 of a DIVU
    @(posedge clk);
    #1;
    drive_req(OP_DIVU, 1000, 3, 7);
    repeat (10) @(posedge clk);
    #1;
    flush_i = 1'b1;
    @(negedge clk);
    chk("flush.start", 32'(div_start_o), 0);
    chk("flush.stall", 32'(stall_o), 0);
    @(posedge clk);
    #1;
    flush_i = 1'b0; req_valid_i = 1'b0;
    cnt = 0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (wb_valid_o || div_start_o) cnt++;
    end
    chk("flush.no_wb", cnt, 0);
    do_op("divu_9_3", OP_DIVU, 9, 3, 7);

    // rd == 0: no stall, no writeback, no divider activity
    @(posedge clk);
    #1;
    drive_req(OP_DIV, 77, 7, 0);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (stall_o || wb_valid_o || div_start_o) cnt++;
    end
    chk("rd0.quiet", cnt, 0);
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;

    // randomized operations, some repeating the previous operands
    a = 0; b = 1; op = OP_DIV;
    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 3) != 0) begin
        op = 3'(4 + $urandom_range(0, 3));
        a  = $urandom;
        case ($urandom_range(0, 7))
          0:       b = 0;
          1, 2:    b = 32'($urandom_range(1, 16));
          3:       b = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
          default: b = $urandom;
        endcase
      end
      do_op($sformatf("rnd%0d", i), op, a, b, 5'($urandom_range(1, 31)));
    end

    // watchdog: divider never ready
    hang = 1;
    @(posedge clk);
    #1;
    drive_req(OP_DIVU, 77, 3, 9);
    cnt = -1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      if (wb_valid_o) chk("wdog.no_wb", 32'(wb_valid_o), 0);
      if (err_o) begin
        cnt = cyc;
        chk("wdog.start", 32'(div_start_o), 0);
        break;
      end
    end
    chk("wdog.err_cyc", cnt, TIMEOUT_CYC);
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
    hang = 0;
    @(negedge clk);
    chk("wdog.err_pulse", 32'(err_o), 0);
    chk("wdog.after_wb", 32'(wb_valid_o), 0);

    // reset in the middle of a run, then the cache must miss
    do_op("pre_rst", OP_DIV, 50, 5, 3);
    @(posedge clk);
    #1;
    drive_req(OP_DIVU, 500, 7, 4);
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst.start_same", 32'(div_start_o), 0);
    @(posedge clk);
    #1;
    rst = 1'b0; req_valid_i = 1'b0;
    rc_vld = 0;
    @(negedge clk);
    chk_all_zero("rst_mid");
    do_op("post_rst", OP_DIV, 50, 5, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
